// File: rtl/onn_update_sequencer_if.sv
// Handshake bundle between the host/pattern loader, the update sequencer and the
// phase-register array: run control in, trigger pulses and run status out.
interface onn_update_sequencer_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [N-1:0]     state_changed;
  logic             re_o;
  logic             drop_o;
  logic             check_o;
  logic             busy;
  logic             done;
  logic             converged;
  logic [CNT_W-1:0] check_count;

  modport master (
    output start, abort, state_changed,
    input  re_o, drop_o, check_o, busy, done, converged, check_count
  );

  modport slave (
    input  start, abort, state_changed,
    output re_o, drop_o, check_o, busy, done, converged, check_count
  );
endinterface

// File: rtl/onn_update_sequencer.sv
// Sequencer for one ONN relaxation run: reset/drop/check trigger pulses to the
// phase-register array, convergence detection over consecutive quiet checks.
module onn_update_sequencer #(
  parameter int N             = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_CHECKS = 2,
  parameter int MAX_CHECKS    = 255,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   re_n,
  onn_update_sequencer_if.slave  bus
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_CHECKS + 1);
  localparam logic [SET_W-1:0] SETTLE_L = SET_W'(SETTLE_CYCLES);
  localparam logic [STB_W-1:0] STABLE_L = STB_W'(STABLE_CHECKS);
  localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_CHECKS);

  typedef enum logic [2:0] {
    IDLE, RESET, GAP, DROP, SETTLE, CHECK, SAMPLE, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             conv_q, conv_d;
  logic             re_q, drop_q, check_q, busy_q, done_q;

  logic [N-1:0]     flags;
  logic             any;
  logic [STB_W-1:0] stable_inc;
  logic [CNT_W-1:0] count_inc;

  assign flags      = bus.state_changed;
  assign any        = |flags;
  assign stable_inc = stable_q + 1'b1;
  assign count_inc  = count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    stable_d = stable_q;
    count_d  = count_q;
    conv_d   = conv_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RESET;
          count_d  = '0;
          stable_d = '0;
          conv_d   = 1'b0;
        end
      end
      RESET: state_d = GAP;
      GAP:   state_d = DROP;
      DROP: begin
        state_d  = SETTLE;
        settle_d = SETTLE_L;
      end
      SETTLE: begin
        if (settle_q == SET_W'(1)) state_d = CHECK;
        else                       settle_d = settle_q - 1'b1;
      end
      CHECK: state_d = SAMPLE;
      SAMPLE: begin
        count_d  = count_inc;
        stable_d = any ? '0 : stable_inc;
        // Convergence wins when the quiet streak completes on the last allowed check
        if (!any && stable_inc == STABLE_L) begin
          state_d = DONE;
          conv_d  = 1'b1;
        end else if (count_inc == MAX_L) begin
          state_d = DONE;
          conv_d  = 1'b0;
        end else begin
          state_d  = SETTLE;
          settle_d = SETTLE_L;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides any SAMPLE update so the count reflects checks already completed
    if (bus.abort && state_q != IDLE && state_q != DONE) begin
      state_d  = IDLE;
      conv_d   = 1'b0;
      count_d  = count_q;
      stable_d = stable_q;
    end
  end

  // Outputs are decoded from the next state so every pulse comes straight off a flop
  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      stable_q <= '0;
      count_q  <= '0;
      conv_q   <= 1'b0;
      re_q     <= 1'b0;
      drop_q   <= 1'b0;
      check_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      stable_q <= stable_d;
      count_q  <= count_d;
      conv_q   <= conv_d;
      re_q     <= (state_d == RESET);
      drop_q   <= (state_d == DROP);
      check_q  <= (state_d == CHECK);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.re_o        = re_q;
  assign bus.drop_o      = drop_q;
  assign bus.check_o     = check_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.converged   = conv_q;
  assign bus.check_count = count_q;

endmodule

// File: tb/tb_onn_update_sequencer.sv
// Bench for onn_update_sequencer: table of whole runs with hand-computed timing,
// plus hand-written reset sequences. Configuration N=4, S=4, STABLE=2, MAX=8.
module tb_onn_update_sequencer;

  logic clk;
  logic re_n;
  int   n_pass;
  int   n_total;

  onn_update_sequencer_if #(.N(4), .CNT_W(8)) bus ();

  onn_update_sequencer #(
    .N(4), .SETTLE_CYCLES(4), .STABLE_CHECKS(2), .MAX_CHECKS(8), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .re_n (re_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] flags;       // nibble k-1 = state_changed answered to check k
    int          abort_cyc;   // -1 none, 0 together with start
    int          busy_start;  // cycle of a start pulse while busy, 0 none
    int          exp_checks;
    int          exp_done;
    int          exp_conv;
    int          exp_count;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int nre = 0, re_cyc = -1, ndrop = 0, drop_cyc = -1;
    int nchk = 0, tmis = 0, ndone = 0, done_cyc = -1;
    int perr = 0, busy_err = 0, conv_at_done = -1, conv1 = -1, cnt1 = -1;
    int last_busy, trig;
    logic prev_trig = 1'b0;
    last_busy = (v.exp_done != 0) ? v.exp_done_cyc : v.abort_cyc;
    @(posedge clk); #1;
    bus.state_changed = 4'b0000;
    bus.start = 1'b1;
    bus.abort = (v.abort_cyc == 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 80; c++) begin
      bus.abort = (c == v.abort_cyc);
      bus.start = (c == v.busy_start);
      if (c == 1) begin
        conv1 = int'(bus.converged);
        cnt1  = int'(bus.check_count);
      end
      trig = int'(bus.re_o) + int'(bus.drop_o) + int'(bus.check_o);
      if (trig > 1) perr++;
      if (trig != 0 && prev_trig) perr++;
      if (bus.re_o && bus.drop_o) perr++;
      prev_trig = (trig != 0);
      if (bus.re_o)   begin nre++;   re_cyc = c;   end
      if (bus.drop_o) begin ndrop++; drop_cyc = c; end
      if (bus.check_o) begin
        nchk++;
        if (c != 8 + 6 * (nchk - 1)) tmis++;
        if (nchk <= 8) bus.state_changed = v.flags[4*(nchk-1) +: 4];
      end
      if (bus.done) begin
        ndone++;
        done_cyc = c;
        conv_at_done = int'(bus.converged);
      end
      if (bus.busy != (c <= last_busy)) busy_err++;
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk({v.name, "/conv_cleared_on_start"}, conv1, 0);
    chk({v.name, "/count_cleared_on_start"}, cnt1, 0);
    chk({v.name, "/re_o_pulses"}, nre, 1);
    chk({v.name, "/re_o_cycle"}, re_cyc, 1);
    chk({v.name, "/drop_o_pulses"}, ndrop, 1);
    chk({v.name, "/drop_o_cycle"}, drop_cyc, 3);
    chk({v.name, "/check_o_pulses"}, nchk, v.exp_checks);
    chk({v.name, "/check_o_timing_errs"}, tmis, 0);
    chk({v.name, "/done_pulses"}, ndone, v.exp_done);
    if (v.exp_done != 0) begin
      chk({v.name, "/done_cycle"}, done_cyc, v.exp_done_cyc);
      chk({v.name, "/converged_at_done"}, conv_at_done, v.exp_conv);
    end
    chk({v.name, "/converged_final"}, int'(bus.converged), v.exp_conv);
    chk({v.name, "/check_count_final"}, int'(bus.check_count), v.exp_count);
    chk({v.name, "/busy_errs"}, busy_err, 0);
    chk({v.name, "/protocol_errs"}, perr, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "/re_o"}, int'(bus.re_o), 0);
    chk({nm, "/drop_o"}, int'(bus.drop_o), 0);
    chk({nm, "/check_o"}, int'(bus.check_o), 0);
    chk({nm, "/busy"}, int'(bus.busy), 0);
    chk({nm, "/done"}, int'(bus.done), 0);
    chk({nm, "/converged"}, int'(bus.converged), 0);
    chk({nm, "/check_count"}, int'(bus.check_count), 0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    re_n    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.state_changed = 4'b0000;

    vecs[0] = '{"quiet",        32'h0000_0000, -1, 0, 2, 1, 1, 2, 16};
    vecs[1] = '{"never_settle", 32'h2222_2222, -1, 0, 8, 1, 0, 8, 52};
    vecs[2] = '{"intermittent", 32'h0000_0401, -1, 0, 5, 1, 1, 5, 34};
    vecs[3] = '{"abort",        32'h1111_1111, 11, 0, 1, 0, 0, 1, 0};
    vecs[4] = '{"start_busy",   32'h0000_0000,  0, 5, 2, 1, 1, 2, 16};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    re_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the SETTLE phase of check 2, after one check has been counted
    @(posedge clk); #1;
    bus.state_changed = 4'b0001;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset/busy", int'(bus.busy), 1);
    chk("pre_reset/check_count", int'(bus.check_count), 1);
    #2;
    re_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    re_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset/busy", int'(bus.busy), 0);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/onn_update_sequencer.md
# onn_update_sequencer

Control sequencer for one ONN relaxation run. Drives the shared reset, drop and check triggers of an array of N phase registers. ORs their per-neuron state-changed flags after every check and declares convergence after STABLE_CHECKS consecutive quiet checks, or gives up at MAX_CHECKS. Sits directly upstream of the phase-register array and downstream of the host/pattern-load logic that raises `start`.

## Interface
- N, 8: number of neurons (width of `state_changed`), ≥1
- SETTLE_CYCLES, 16: cycles the oscillators run between checks, ≥1
- STABLE_CHECKS, 2: consecutive all-quiet checks required for convergence, ≥1
- MAX_CHECKS, 255: check limit before timeout, 1..2^CNT_W−1
- CNT_W, 8: width of the check counter

- clk  in  1  system clock, all state on rising edge
- re_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel a run; sampled in every busy state
- state_changed  in  N  per-neuron changed flags from the phase registers
- re_o  out  1  reset trigger to phase registers, one-cycle pulse
- drop_o  out  1  drop (load initial phase) trigger, one-cycle pulse
- check_o  out  1  phase-check trigger, one-cycle pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run ends (not on abort)
- converged  out  1  result of last run; valid from `done`, held until next accepted `start`
- check_count  out  CNT_W  checks issued in current/last run

## Operation
- States: IDLE, RESET, GAP, DROP, SETTLE, CHECK, SAMPLE, DONE.
- IDLE: `start`=1 → RESET. Clear `converged`, `check_count` and the stable counter.
- RESET: `re_o`=1 for this cycle → GAP.
- GAP: all triggers low for one cycle → DROP. Keeps `re_o` and `drop_o` from overlapping and gives the downstream edge detectors a low cycle.
- DROP: `drop_o`=1 for this cycle → SETTLE with the settle counter loaded.
- SETTLE: stay exactly SETTLE_CYCLES cycles → CHECK.
- CHECK: `check_o`=1 for this cycle → SAMPLE.
- SAMPLE evaluates `any` = OR of `state_changed`:
  - `check_count` increments.
  - Stable counter: cleared if `any`, else incremented.
  - If the new stable count = STABLE_CHECKS → DONE with `converged`=1.
  - Else if the new `check_count` = MAX_CHECKS → DONE with `converged`=0.
  - Else → SETTLE.
  - Convergence takes priority when both conditions hit on the same check.
- DONE: `done`=1 for one cycle → IDLE.
- Abort: `abort`=1 in any state other than IDLE or DONE → IDLE on the next edge.
  - All triggers low.
  - No `done` pulse; `converged`=0.
  - `check_count` holds its value.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `start` wins (abort has no effect in IDLE).
- Trigger outputs are registered, never high in two consecutive cycles, and never more than one high at a time.

## Timing
- Reset (`re_n`=0, asynchronous): state IDLE; `re_o`, `drop_o`, `check_o`, `busy`, `done`, `converged` = 0; `check_count` and the internal counters = 0. Reset mid-run aborts immediately with no pulse.
- Cycle numbering: `start` sampled at the edge ending cycle 0.
  - `re_o` high in cycle 1; GAP in cycle 2; `drop_o` high in cycle 3.
  - SETTLE occupies cycles 4..3+S (S = SETTLE_CYCLES).
  - First `check_o` high in cycle 4+S; SAMPLE in cycle 5+S.
- `state_changed` is sampled at the edge ending SAMPLE, one full cycle after the `check_o` cycle. This covers the one-cycle edge-detect latency of the phase registers.
- Check period: S+2 cycles.
- DONE follows the deciding SAMPLE directly:
  - `done` in cycle 6+S+(k−1)(S+2) for a run ending on check k.
  - `busy` falls in the following cycle.
- `busy` rises in cycle 1, the cycle after `start` is accepted.

## Test plan
Configuration for all scenarios: N=4, S=4, STABLE_CHECKS=2, MAX_CHECKS=8.
- Reset: assert `re_n`=0 during SETTLE → all outputs 0 at once; after release, `start` runs from cycle 1 normally.
- Quiet array: `state_changed`=4'b0000 always, `start` at cycle 0 → `re_o`@1, `drop_o`@3, `check_o`@8 and @14, `done`@16, `converged`=1, `check_count`=2.
- Never settles: `state_changed`=4'b0010 always → 8 `check_o` pulses, `done` with `converged`=0, `check_count`=8.
- Intermittent: flags per check 0001, 0000, 0100, 0000, 0000 → stable counter restarts; `converged`=1 at check 5, `check_count`=5.
- Abort: `abort` in the 2nd SETTLE cycle of check 2 → IDLE next cycle, no `done`, `converged`=0, `check_count`=1, no further triggers.
- Protocol: `start` pulsed while busy → ignored. Check on every cycle that at most one trigger is high, no trigger is high in two consecutive cycles, and `re_o` never overlaps `drop_o`.
